edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N_CH, default 4, sets the number of monitored input channels (legal range 2..16).
REQ-002 Parameter CH_W, default $clog2(N_CH), sets the channel index width.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sig_in  input  N_CH  level inputs, one bit per channel, synchronous to clk.
REQ-006 evt_valid  output  1  an edge event is offered.
REQ-007 evt_ready  input  1  the consumer accepts the offered event.
REQ-008 evt_ch  output  CH_W  channel index of the offered event.
REQ-009 evt_rise  output  1  1 means a rising-edge event, 0 means a falling-edge event.
REQ-010 ovf  output  N_CH  sticky per-channel overflow flags.
REQ-011 ovf_clr  input  N_CH  per-channel overflow clear, one-cycle pulse.

Function
REQ-012 Each channel SHALL register sig_in into sig_d every cycle; rise = sig_in & ~sig_d, fall = ~sig_in & sig_d.
REQ-013 A detected rise SHALL set pend_rise[ch] at that clock edge, and a detected fall SHALL set pend_fall[ch] at that clock edge.
REQ-014 An edge detected while the same-type pending bit is already set and not being cleared in that cycle SHALL set ovf[ch]; the event stays single-pending.
REQ-015 The FSM SHALL have two states, IDLE and OFFER.
REQ-016 In IDLE with any pending bit set, the FSM SHALL select a channel round-robin starting at rr_ptr, latch evt_ch and evt_rise, and go to OFFER.
REQ-017 In IDLE with no pending bit set, the FSM SHALL remain in IDLE.
REQ-018 evt_valid SHALL be 1 exactly when the FSM is in OFFER.
REQ-019 evt_ch and evt_rise SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-020 Acceptance is evt_valid & evt_ready at a clock edge; on acceptance the FSM SHALL clear the offered pending bit, set rr_ptr to (evt_ch+1) mod N_CH, and return to IDLE.
REQ-021 A channel with both pend_rise and pend_fall set SHALL be offered as rise first.
REQ-022 Latency: for an edge sampled at clock edge t, evt_valid SHALL assert after edge t+1 when the FSM is idle and no other channel wins.
REQ-023 The minimum spacing between accepted events SHALL be 2 cycles (OFFER followed by IDLE).
REQ-024 If a new same-type edge and acceptance of that pending bit occur in the same cycle, the set SHALL win, the bit SHALL remain pending, and ovf SHALL NOT be set.
REQ-025 ovf_clr[ch] SHALL clear ovf[ch]; if ovf_clr[ch] and a new overflow occur in the same cycle, the set SHALL win.
REQ-026 rr_ptr wrap: when rr_ptr=N_CH-1, the search SHALL continue at channel 0.

Reset
REQ-027 While reset=1, the block SHALL hold sig_d=0, all pending bits=0, ovf=0, rr_ptr=0, FSM=IDLE, evt_valid=0, evt_ch=0 and evt_rise=0.
REQ-028 Reset asserted mid-OFFER SHALL drop evt_valid immediately (asynchronously) and discard all pending events.
REQ-029 A sig_in bit held high at reset release SHALL produce one rising event, because sig_d resets to 0.

Configuration
REQ-030 Macro EDGE_ARB_FALLING_EN defined: falling edges SHALL be detected, queued and offered with evt_rise=0.
REQ-031 Macro EDGE_ARB_FALLING_EN undefined: pend_fall logic SHALL be absent, falling edges SHALL be ignored, and evt_rise SHALL be tied to 1.

Structure
REQ-032 Package edge_arb_pkg SHALL hold the FSM state typedef (IDLE, OFFER) and the round-robin next-index function.
REQ-033 Sub-module edge_capture SHALL implement one channel: sig_d, pend_rise, pend_fall, ovf, and the set/clear priority rules; the top level SHALL instantiate it N_CH times.

Verification
REQ-034 After reset, pulse sig_in[2] 0->1 with evt_ready=1 -> evt_valid=1 for one cycle, 2 cycles later, with evt_ch=2 and evt_rise=1.
REQ-035 sig_in 0000->1111 in one cycle, evt_ready=1 -> events on channels 0,1,2,3 in order, each 2 cycles apart; rr_ptr then equals 0.
REQ-036 Hold evt_ready=0 while ch1 rises, falls and rises again (FALLING_EN defined) -> evt_ch=1 stays stable and ovf[1]=1; after ovf_clr[1], ovf[1]=0.
REQ-037 ch0 rises on the exact accept cycle of the pending ch0 rise -> a second ch0 rise event follows and ovf[0] stays 0.
REQ-038 FALLING_EN undefined: toggle ch3 1->0 -> no event; toggle 0->1 -> one event with evt_rise=1.
REQ-039 Assert reset during OFFER with 3 channels pending -> evt_valid=0 immediately, no events after release, and a held-high input yields one rise event.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// rtl/edge_arb_pkg.sv - shared FSM state type and round-robin helper for edge_event_arbiter
package edge_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Channel after idx, wrapping from n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/edge_capture.sv
// rtl/edge_capture.sv - one channel: edge detect, pending flags, sticky overflow
// Falling-edge path exists only when EDGE_ARB_FALLING_EN is defined.
module edge_capture (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  input  logic clr_rise,
`ifdef EDGE_ARB_FALLING_EN
  input  logic clr_fall,
`endif
  input  logic ovf_clr,
  output logic pend_rise,
`ifdef EDGE_ARB_FALLING_EN
  output logic pend_fall,
`endif
  output logic ovf
);

  logic sig_d;
  logic rise;
  logic ovf_set;

  assign rise = sig & ~sig_d;

`ifdef EDGE_ARB_FALLING_EN
  logic fall;
  assign fall    = ~sig & sig_d;
  assign ovf_set = (rise & pend_rise & ~clr_rise) | (fall & pend_fall & ~clr_fall);
`else
  assign ovf_set = rise & pend_rise & ~clr_rise;
`endif

  // A new edge beats a same-cycle clear, so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_d     <= 1'b0;
      pend_rise <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      sig_d <= sig;
      if (rise)          pend_rise <= 1'b1;
      else if (clr_rise) pend_rise <= 1'b0;
      if (ovf_set)       ovf <= 1'b1;
      else if (ovf_clr)  ovf <= 1'b0;
    end
  end

`ifdef EDGE_ARB_FALLING_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_fall <= 1'b0;
    end else begin
      if (fall)          pend_fall <= 1'b1;
      else if (clr_fall) pend_fall <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - round-robin arbiter offering per-channel edge events
// Define EDGE_ARB_FALLING_EN to also detect and offer falling edges.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sig_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf,
  input  logic [N_CH-1:0] ovf_clr
);

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch_q, ch_nxt;
  logic [CH_W-1:0]   rr_ptr, rr_nxt;
  logic [N_CH-1:0]   pend_rise;
  logic [N_CH-1:0]   clr_rise;
  logic [N_CH-1:0]   pending;
  logic              found;
  logic [CH_W-1:0]   sel;

`ifdef EDGE_ARB_FALLING_EN
  logic [N_CH-1:0]   pend_fall;
  logic [N_CH-1:0]   clr_fall;
  logic              rise_q, rise_nxt;
  assign pending  = pend_rise | pend_fall;
  assign evt_rise = rise_q;
`else
  assign pending  = pend_rise;
  assign evt_rise = 1'b1;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_capture u_cap (
      .clk       (clk),
      .reset     (reset),
      .sig       (sig_in[g]),
      .clr_rise  (clr_rise[g]),
`ifdef EDGE_ARB_FALLING_EN
      .clr_fall  (clr_fall[g]),
`endif
      .ovf_clr   (ovf_clr[g]),
      .pend_rise (pend_rise[g]),
`ifdef EDGE_ARB_FALLING_EN
      .pend_fall (pend_fall[g]),
`endif
      .ovf       (ovf[g])
    );
  end

  // First pending channel at or after rr_ptr, wrapping past N_CH-1 to 0.
  always_comb begin
    logic [CH_W:0] sum;
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
      if (!found && pending[sum[CH_W-1:0]]) begin
        found = 1'b1;
        sel   = sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch_q;
    rr_nxt    = rr_ptr;
    clr_rise  = '0;
`ifdef EDGE_ARB_FALLING_EN
    rise_nxt  = rise_q;
    clr_fall  = '0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          ch_nxt    = sel;
`ifdef EDGE_ARB_FALLING_EN
          rise_nxt  = pend_rise[sel];
`endif
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
`ifdef EDGE_ARB_FALLING_EN
          clr_rise[ch_q] = rise_q;
          clr_fall[ch_q] = ~rise_q;
`else
          clr_rise[ch_q] = 1'b1;
`endif
          rr_nxt    = CH_W'(rr_next(int'(ch_q), N_CH));
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ch_q   <= '0;
      rr_ptr <= '0;
`ifdef EDGE_ARB_FALLING_EN
      rise_q <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      ch_q   <= ch_nxt;
      rr_ptr <= rr_nxt;
`ifdef EDGE_ARB_FALLING_EN
      rise_q <= rise_nxt;
`endif
    end
  end

  assign evt_valid = (state == OFFER);
  assign evt_ch    = ch_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - randomized and directed bench with behavioural event model
module tb_edge_event_arbiter;

  localparam int N = 4;
  localparam int W = 2;
`ifdef EDGE_ARB_FALLING_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sig = '0;
  logic         ready = 1'b0;
  logic [N-1:0] clr = '0;
  logic         evt_valid;
  logic [W-1:0] evt_ch;
  logic         evt_rise;
  logic [N-1:0] ovf;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  edge_event_arbiter #(.N_CH(N), .CH_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig),
    .evt_valid (evt_valid),
    .evt_ready (ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: pending flags per channel and edge type, one offered event at a time.
  logic [N-1:0] m_prev, m_pr, m_pf, m_ovf, o_pr, o_pf;
  bit m_off, m_rise, acc, r, f, cr, cf, oset, found;
  int m_ch, m_rr, c;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prev = '0; m_pr = '0; m_pf = '0; m_ovf = '0;
      m_off = 0; m_rise = 0; m_ch = 0; m_rr = 0;
    end else begin
      o_pr = m_pr;
      o_pf = m_pf;
      acc  = m_off && ready;
      for (int k = 0; k < N; k++) begin
        r  = sig[k] && !m_prev[k];
        f  = FALL_EN && !sig[k] && m_prev[k];
        cr = acc && (m_ch == k) && m_rise;
        cf = acc && (m_ch == k) && !m_rise;
        oset = (r && o_pr[k] && !cr) || (f && o_pf[k] && !cf);
        if (r) m_pr[k] = 1; else if (cr) m_pr[k] = 0;
        if (f) m_pf[k] = 1; else if (cf) m_pf[k] = 0;
        if (oset) m_ovf[k] = 1; else if (clr[k]) m_ovf[k] = 0;
      end
      m_prev = sig;
      if (m_off) begin
        if (acc) begin
          m_off = 0;
          m_rr  = (m_ch + 1) % N;
        end
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!found && (o_pr[c] || o_pf[c])) begin
            found  = 1;
            m_off  = 1;
            m_ch   = c;
            m_rise = o_pr[c];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_valid", evt_valid, m_off);
      if (m_off) begin
        check("model_ch", evt_ch, m_ch);
        check("model_rise", evt_rise, m_rise);
      end
      check("model_ovf", ovf, m_ovf);
    end
  end

  task automatic do_reset();
    reset = 1; sig = '0; ready = 0; clr = '0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic wait_valid(input string name, input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (evt_valid) seen = 1;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  int cnt, cyc_q[$], ch_q[$], seen_ch;

  initial begin
    do_reset();
    chk_en = 1;
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_ch", evt_ch, 0);
    check("rst_rise", evt_rise, FALL_EN ? 0 : 1);
    check("rst_ovf", ovf, 0);

    // Single rise on ch2: offered two edges after the edge is sampled.
    ready = 1; sig[2] = 1;
    @(negedge clk); check("r034_lat", evt_valid, 0);
    @(negedge clk);
    check("r034_valid", evt_valid, 1);
    check("r034_ch", evt_ch, 2);
    check("r034_rise", evt_rise, 1);
    @(negedge clk); check("r034_drop", evt_valid, 0);

    // All four rise together: served 0..3, two cycles apart, pointer wraps to 0.
    do_reset();
    ready = 1; sig = 4'hF;
    cyc_q.delete(); ch_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (evt_valid) begin cyc_q.push_back(i); ch_q.push_back(evt_ch); end
    end
    check("r035_count", cyc_q.size(), 4);
    for (int i = 0; i < 4 && i < ch_q.size(); i++) check("r035_order", ch_q[i], i);
    for (int i = 1; i < 4 && i < cyc_q.size(); i++) check("r035_gap", cyc_q[i] - cyc_q[i-1], 2);
    check("r035_rr", dut.rr_ptr, 0);

    // Stalled offer on ch1 while a second rise arrives: overflow, stable offer, then clear.
    do_reset();
    sig[1] = 1;
    wait_valid("r036", 6);
    check("r036_ch", evt_ch, 1);
    sig[1] = 0;
    @(negedge clk); sig[1] = 1;
    @(negedge clk);
    check("r036_hold", evt_ch, 1);
    check("r036_ovf", ovf[1], 1);
    clr[1] = 1;
    @(negedge clk); clr[1] = 0;
    check("r036_clr", ovf[1], 0);
    ready = 1;
    repeat (12) @(negedge clk);

    // New ch0 rise lands on the accept edge of the pending ch0 rise.
    do_reset();
    sig[0] = 1;
    wait_valid("r037", 6);
    check("r037_ch", evt_ch, 0);
    sig[0] = 0;
    @(negedge clk); sig[0] = 1; ready = 1;
    @(negedge clk);
    check("r037_idle", evt_valid, 0);
    check("r037_ovf", ovf[0], 0);
    @(negedge clk);
    check("r037_again", evt_valid, 1);
    check("r037_again_ch", evt_ch, 0);
    check("r037_again_rise", evt_rise, 1);
    repeat (8) @(negedge clk);

`ifndef EDGE_ARB_FALLING_EN
    // Falling edges are ignored; the following rise is offered once.
    do_reset();
    ready = 1; sig[3] = 1;
    repeat (8) @(negedge clk);
    sig[3] = 0; cnt = 0;
    repeat (8) begin @(negedge clk); if (evt_valid) cnt++; end
    check("r038_fall", cnt, 0);
    sig[3] = 1; cnt = 0;
    repeat (8) begin @(negedge clk); if (evt_valid) begin cnt++; check("r038_rise", evt_rise, 1); end end
    check("r038_count", cnt, 1);
`endif

    // Reset during an offer with three channels pending.
    do_reset();
    sig = 4'b0111;
    wait_valid("r039", 6);
    reset = 1; sig = 4'b0001;
    #1 check("r039_async", evt_valid, 0);
    repeat (2) @(negedge clk);
    reset = 0; ready = 1; cnt = 0; seen_ch = -1;
    repeat (12) begin @(negedge clk); if (evt_valid) begin cnt++; seen_ch = evt_ch; end end
    check("r039_count", cnt, 1);
    check("r039_ch", seen_ch, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
      end
      sig   = sig ^ N'($urandom & $urandom);
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
